// File: rtl/nmea_pkg.sv
// Shared types and character constants for the NMEA sentence parser.
package nmea_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BODY    = 3'd1,
        CSUM_HI = 3'd2,
        CSUM_LO = 3'd3,
        EOL     = 3'd4,
        HOLD    = 3'd5
    } nmea_state_e;

    localparam logic [7:0] CHAR_DOLLAR = 8'h24;
    localparam logic [7:0] CHAR_STAR   = 8'h2A;
    localparam logic [7:0] CHAR_CR     = 8'h0D;
    localparam logic [7:0] CHAR_LF     = 8'h0A;

endpackage

// File: rtl/nmea_hex_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f to a nibble plus a valid flag.
module nmea_hex_decode (
    input  logic [7:0] ch_i,
    output logic [3:0] nibble_o,
    output logic       is_hex_o
);

    always_comb begin
        nibble_o = 4'h0;
        is_hex_o = 1'b0;
        if (ch_i >= 8'h30 && ch_i <= 8'h39) begin
            nibble_o = 4'(ch_i - 8'h30);
            is_hex_o = 1'b1;
        end else if (ch_i >= 8'h41 && ch_i <= 8'h46) begin
            nibble_o = 4'(ch_i - 8'h37);
            is_hex_o = 1'b1;
        end else if (ch_i >= 8'h61 && ch_i <= 8'h66) begin
            nibble_o = 4'(ch_i - 8'h57);
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/nmea_sentence_parser.sv
// Assembles "$...*HH[CR]LF" sentences from a character stream, verifies the XOR checksum
// and presents the whole sentence on a valid/ready output; errors are one-cycle pulses.
module nmea_sentence_parser
    import nmea_pkg::*;
#(
    parameter int N_BITS    = 8,
    parameter int WORD_SIZE = 79
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_BITS-1:0]             s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [N_BITS*WORD_SIZE-1:0]   sentence_tdata,
    output logic [$clog2(WORD_SIZE+1)-1:0] sentence_len,
    output logic                          sentence_tvalid,
    input  logic                          sentence_tready,
    output logic                          err_checksum,
    output logic                          err_overflow,
    output logic                          err_format,
    output nmea_state_e                   dbg_state_o
);

    localparam int LW = $clog2(WORD_SIZE+1);
    localparam logic [LW-1:0] MAX_LEN = LW'(WORD_SIZE);

    nmea_state_e               state_q, state_d;
    logic [N_BITS*WORD_SIZE-1:0] buf_q, buf_d;
    logic [LW-1:0]             len_q, len_d;
    logic [7:0]                xor_q, xor_d;
    logic [7:0]                rx_csum_q, rx_csum_d;
    logic                      err_cs_q, err_cs_d;
    logic                      err_ov_q, err_ov_d;
    logic                      err_fmt_q, err_fmt_d;

    logic [7:0] ch;
    logic [3:0] hex_nib;
    logic       is_hex;
    logic       acc;
    logic       abort;
    logic       full;

    assign ch   = s_tdata[7:0];
    assign full = (len_q == MAX_LEN);

    nmea_hex_decode u_hex (
        .ch_i     (ch),
        .nibble_o (hex_nib),
        .is_hex_o (is_hex)
    );

    // A character moves on clk when s_tvalid && s_tready; a sentence moves when
    // sentence_tvalid && sentence_tready. Valid never depends on ready.
    assign s_tready        = (state_q != HOLD);
    assign acc             = s_tvalid && s_tready;
    assign sentence_tvalid = (state_q == HOLD);
    assign sentence_tdata  = buf_q;
    assign sentence_len    = len_q;
    assign err_checksum    = err_cs_q;
    assign err_overflow    = err_ov_q;
    assign err_format      = err_fmt_q;
    assign dbg_state_o     = state_q;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        len_d     = len_q;
        xor_d     = xor_q;
        rx_csum_d = rx_csum_q;
        err_cs_d  = 1'b0;
        err_ov_d  = 1'b0;
        err_fmt_d = 1'b0;
        abort     = 1'b0;

        if (acc) begin
            if (ch == CHAR_DOLLAR) begin
                // '$' always starts over, silently dropping any partial sentence
                buf_d               = '0;
                buf_d[N_BITS-1:0]   = s_tdata;
                len_d               = LW'(1);
                xor_d               = 8'h00;
                rx_csum_d           = 8'h00;
                state_d             = BODY;
            end else begin
                case (state_q)
                    BODY: begin
                        if (ch == CHAR_CR || ch == CHAR_LF) begin
                            err_fmt_d = 1'b1;
                            abort     = 1'b1;
                        end else if (full) begin
                            err_ov_d = 1'b1;
                            abort    = 1'b1;
                        end else begin
                            buf_d[N_BITS*int'(len_q) +: N_BITS] = s_tdata;
                            len_d = len_q + 1'b1;
                            if (ch == CHAR_STAR) state_d = CSUM_HI;
                            else                 xor_d   = xor_q ^ ch;
                        end
                    end
                    CSUM_HI, CSUM_LO: begin
                        if (!is_hex) begin
                            err_fmt_d = 1'b1;
                            abort     = 1'b1;
                        end else if (full) begin
                            err_ov_d = 1'b1;
                            abort    = 1'b1;
                        end else begin
                            buf_d[N_BITS*int'(len_q) +: N_BITS] = s_tdata;
                            len_d = len_q + 1'b1;
                            if (state_q == CSUM_HI) begin
                                rx_csum_d[7:4] = hex_nib;
                                state_d        = CSUM_LO;
                            end else begin
                                rx_csum_d[3:0] = hex_nib;
                                state_d        = EOL;
                            end
                        end
                    end
                    EOL: begin
                        if (ch == CHAR_LF) begin
                            if (xor_q == rx_csum_q) begin
                                state_d = HOLD;
                            end else begin
                                err_cs_d = 1'b1;
                                abort    = 1'b1;
                            end
                        end else if (ch != CHAR_CR) begin
                            err_fmt_d = 1'b1;
                            abort     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (abort) begin
            buf_d   = '0;
            len_d   = '0;
            state_d = IDLE;
        end

        if (state_q == HOLD && sentence_tready) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            len_q     <= '0;
            xor_q     <= 8'h00;
            rx_csum_q <= 8'h00;
            err_cs_q  <= 1'b0;
            err_ov_q  <= 1'b0;
            err_fmt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            len_q     <= len_d;
            xor_q     <= xor_d;
            rx_csum_q <= rx_csum_d;
            err_cs_q  <= err_cs_d;
            err_ov_q  <= err_ov_d;
            err_fmt_q <= err_fmt_d;
        end
    end

endmodule

// File: tb/tb_nmea_sentence_parser.sv
// Directed bench for nmea_sentence_parser: sentences, checksum/format/overflow errors,
// back-pressure hold and asynchronous reset.
module tb_nmea_sentence_parser;
    import nmea_pkg::*;

    localparam int NB = 8;
    localparam int WS = 79;
    localparam int W  = NB*WS;
    localparam int LW = $clog2(WS+1);

    logic          clk;
    logic          rst;
    logic [NB-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [W-1:0]  sentence_tdata;
    logic [LW-1:0] sentence_len;
    logic          sentence_tvalid;
    logic          sentence_tready;
    logic          err_checksum;
    logic          err_overflow;
    logic          err_format;
    nmea_state_e   dbg_state;

    int errors = 0;
    int checks = 0;
    int cnt_cs = 0;
    int cnt_ov = 0;
    int cnt_fmt = 0;
    int n_sent = 0;
    logic [W-1:0]  got_data;
    logic [LW-1:0] exp_q[$];
    logic [W-1:0]  exp_data;

    nmea_sentence_parser #(.N_BITS(NB), .WORD_SIZE(WS)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .sentence_tdata  (sentence_tdata),
        .sentence_len    (sentence_len),
        .sentence_tvalid (sentence_tvalid),
        .sentence_tready (sentence_tready),
        .err_checksum    (err_checksum),
        .err_overflow    (err_overflow),
        .err_format      (err_format),
        .dbg_state_o     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: counts error-pulse cycles and scoreboards delivered sentence lengths
    always @(negedge clk) begin
        if (rst) begin
            cnt_cs  += int'(err_checksum);
            cnt_ov  += int'(err_overflow);
            cnt_fmt += int'(err_format);
            if (sentence_tvalid && sentence_tready) begin
                n_sent++;
                got_data = sentence_tdata;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL unexpected_sentence observed len=%0d expected=none", sentence_len);
                end else begin
                    logic [LW-1:0] e;
                    e = exp_q.pop_front();
                    assert (sentence_len === e) else begin
                        errors++;
                        $error("FAIL sentence_len observed=%0d expected=%0d", sentence_len, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic send_char(input logic [7:0] c);
        int guard;
        guard = 0;
        @(negedge clk);
        s_tdata  = c;
        s_tvalid = 1'b1;
        while (!s_tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        assert (guard < 200) else begin
            errors++;
            $error("FAIL send_timeout observed=%0d expected=<200", guard);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst             = 1'b0;
        s_tdata         = '0;
        s_tvalid        = 1'b0;
        sentence_tready = 1'b1;

        // reset state
        idle(2);
        chk("rst_tvalid", 64'(sentence_tvalid), 64'd0);
        chk("rst_len", 64'(sentence_len), 64'd0);
        chk_data("rst_data", sentence_tdata, '0);
        chk("rst_errs", 64'({err_checksum, err_overflow, err_format}), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        chk("rst_s_tready", 64'(s_tready), 64'd1);
        rst = 1'b1;
        idle(1);

        // "$A*41\r\n"
        exp_q.push_back(LW'(5));
        send_str("$A*41"); send_char(CHAR_CR); send_char(CHAR_LF);
        idle(3);
        chk("s1_count", 64'(n_sent), 64'd1);
        exp_data = '0; exp_data[39:0] = 40'h31342A4124;
        chk_data("s1_data", got_data, exp_data);

        // "$AB*03\n" without CR
        exp_q.push_back(LW'(6));
        send_str("$AB*03"); send_char(CHAR_LF);
        idle(3);
        chk("s2_count", 64'(n_sent), 64'd2);
        exp_data = '0; exp_data[47:0] = 48'h33302A424124;
        chk_data("s2_data", got_data, exp_data);

        // bad checksum
        send_str("$AB*04"); send_char(CHAR_CR); send_char(CHAR_LF);
        idle(3);
        chk("cs_pulse_cycles", 64'(cnt_cs), 64'd1);
        chk("cs_no_sentence", 64'(n_sent), 64'd2);
        chk("cs_state", 64'(dbg_state), 64'(IDLE));

        // restart on '$'
        exp_q.push_back(LW'(6));
        send_str("$A$AB*03"); send_char(CHAR_CR); send_char(CHAR_LF);
        idle(3);
        chk("rs_count", 64'(n_sent), 64'd3);
        chk_data("rs_data", got_data, exp_data);
        chk("rs_no_err", 64'(cnt_cs + cnt_ov + cnt_fmt), 64'd1);

        // overflow: '$' + 79 'X'
        send_char(CHAR_DOLLAR);
        for (int i = 0; i < 78; i++) send_char(8'h58);
        idle(2);
        chk("ov_before", 64'(cnt_ov), 64'd0);
        chk("ov_len_full", 64'(sentence_len), 64'd79);
        send_char(8'h58);
        idle(2);
        chk("ov_pulse", 64'(cnt_ov), 64'd1);
        chk("ov_state", 64'(dbg_state), 64'(IDLE));
        exp_q.push_back(LW'(5));
        send_str("$A*41"); send_char(CHAR_LF);
        idle(3);
        chk("ov_after_count", 64'(n_sent), 64'd4);
        exp_data = '0; exp_data[39:0] = 40'h31342A4124;
        chk_data("ov_after_data", got_data, exp_data);

        // back-pressure hold
        sentence_tready = 1'b0;
        exp_q.push_back(LW'(5));
        send_str("$A*41"); send_char(CHAR_LF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_tvalid", 64'(sentence_tvalid), 64'd1);
            chk("hold_s_tready", 64'(s_tready), 64'd0);
            chk("hold_len", 64'(sentence_len), 64'd5);
            chk_data("hold_data", sentence_tdata, exp_data);
        end
        @(posedge clk);
        #1;
        sentence_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_release_state", 64'(dbg_state), 64'(IDLE));
        chk("hold_release_tvalid", 64'(sentence_tvalid), 64'd0);
        chk("hold_count", 64'(n_sent), 64'd5);

        // non-hex checksum digit
        send_str("$AB*0G"); send_char(CHAR_LF);
        idle(3);
        chk("fmt_pulse", 64'(cnt_fmt), 64'd1);
        chk("fmt_no_sentence", 64'(n_sent), 64'd5);

        // asynchronous reset mid-sentence
        send_str("$AB*");
        @(negedge clk);
        exp_data = '0; exp_data[31:0] = 32'h2A424124;
        chk_data("mid_data", sentence_tdata, exp_data);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_tvalid", 64'(sentence_tvalid), 64'd0);
        chk("arst_len", 64'(sentence_len), 64'd0);
        chk_data("arst_data", sentence_tdata, '0);
        chk("arst_errs", 64'({err_checksum, err_overflow, err_format}), 64'd0);
        chk("arst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(LW'(5));
        send_str("$A*41"); send_char(CHAR_LF);
        idle(3);
        chk("post_rst_count", 64'(n_sent), 64'd6);
        exp_data = '0; exp_data[39:0] = 40'h31342A4124;
        chk_data("post_rst_data", got_data, exp_data);

        chk("final_errs", 64'(cnt_cs + cnt_ov + cnt_fmt), 64'd3);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nmea_sentence_parser.md
NMEA_SENTENCE_PARSER -- requirements
Module: nmea_sentence_parser

Interface
REQ-001 SHALL have parameter N_BITS, default 8: character width in bits.
REQ-002 SHALL have parameter WORD_SIZE, default 79: maximum stored sentence length in characters, NMEA limit.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_tdata, input, N_BITS: received UART character.
REQ-006 SHALL have port s_tvalid, input, 1: s_tdata valid.
REQ-007 SHALL have port s_tready, output, 1: character accepted when s_tvalid and s_tready are both high.
REQ-008 SHALL have port sentence_tdata, output, N_BITS*WORD_SIZE: stored sentence; character k in bits [N_BITS*k +: N_BITS]; unused characters zero.
REQ-009 SHALL have port sentence_len, output, $clog2(WORD_SIZE+1): number of valid characters in sentence_tdata.
REQ-010 SHALL have port sentence_tvalid, output, 1: sentence and length valid.
REQ-011 SHALL have port sentence_tready, input, 1: consumer accepts the sentence.
REQ-012 SHALL have port err_checksum, output, 1: one-cycle pulse on checksum mismatch.
REQ-013 SHALL have port err_overflow, output, 1: one-cycle pulse when a sentence exceeds WORD_SIZE characters.
REQ-014 SHALL have port err_format, output, 1: one-cycle pulse on a malformed sentence.

Function
REQ-015 SHALL implement FSM states IDLE, BODY, CSUM_HI, CSUM_LO, EOL, HOLD.
REQ-016 IDLE: discard every character except '$' (0x24); on '$', clear buffer and XOR, store '$' at index 0, set length 1, go to BODY.
REQ-017 BODY: store each character, XOR it into the running checksum; on '*' (0x2A), store it without XOR and go to CSUM_HI.
REQ-018 CSUM_HI/CSUM_LO: accept one ASCII hex digit each (0-9, A-F, a-f), store it, and form the received checksum as HI in bits [7:4], LO in bits [3:0]; go to EOL after LO.
REQ-019 EOL: CR (0x0D) SHALL be ignored without storing; LF (0x0A) completes the sentence.
REQ-020 On completion with matching checksum: go to HOLD and assert sentence_tvalid on the cycle after the LF handshake.
REQ-021 On completion with mismatched checksum: pulse err_checksum, go to IDLE, and do not assert sentence_tvalid.
REQ-022 On a non-hex digit in CSUM_HI/CSUM_LO, CR/LF in BODY, or any other character in EOL: pulse err_format and go to IDLE.
REQ-023 On '$' in any non-IDLE, non-HOLD state: restart as in REQ-016; no error pulse; the partial sentence is dropped.
REQ-024 If storing a character would make length exceed WORD_SIZE: pulse err_overflow, discard the sentence, and go to IDLE.
REQ-025 HOLD: s_tready=0; sentence_tdata and sentence_len stable; sentence_tvalid=1 until sentence_tready=1, then go to IDLE on the next cycle.
REQ-026 s_tready SHALL be 1 in all states except HOLD.
REQ-027 At most one error pulse SHALL occur per cycle; error pulses are mutually exclusive by construction.

Reset
REQ-028 rst low SHALL asynchronously force: state IDLE, sentence_tvalid 0, all err_* outputs 0, sentence_len 0, sentence_tdata 0, checksum accumulator 0.
REQ-029 Reset mid-sentence or in HOLD SHALL discard all data; after release, the first accepted character is processed as in IDLE.

Structure
REQ-030 A shared package nmea_pkg SHALL hold the state enum and the character constants CHAR_DOLLAR, CHAR_STAR, CHAR_CR, and CHAR_LF.
REQ-031 One sub-module, nmea_hex_decode, SHALL be combinational and output ASCII-to-nibble plus an is_hex flag.

Verification
REQ-032 Input "$A*41\r\n" SHALL produce sentence_tvalid with len 5 and bytes 24 41 2A 34 31; no error.
REQ-033 Input "$AB*03\n" (no CR) SHALL produce len 6 and a valid sentence; "$AB*04\r\n" SHALL produce err_checksum=1 for one cycle and no sentence_tvalid.
REQ-034 Input "$A$AB*03\r\n" SHALL produce exactly one sentence, len 6, starting "$AB".
REQ-035 Input '$' followed by 79 'X' characters SHALL produce err_overflow on the 80th stored character; a subsequent "$A*41\n" SHALL parse correctly.
REQ-036 With sentence_tready=0 for 20 cycles after "$A*41\n": sentence_tvalid SHALL stay 1, s_tready SHALL stay 0, and the data SHALL stay stable; when sentence_tready=1, IDLE SHALL follow next cycle.
REQ-037 Input "$AB*0G\n" SHALL produce err_format; rst low mid-sentence SHALL make all outputs zero immediately.
